// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver/transmitter states and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: receiver-to-RX-FIFO write port with status flags
interface uart_rx_core_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic fifo_full;
  logic frame_err;
  logic overrun;
  logic busy;
  modport master(output rx_data, rx_valid, frame_err, overrun, busy, input fifo_full);
  modport slave(input rx_data, rx_valid, frame_err, overrun, busy, output fifo_full);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle oversample tick
module uart_baud_tick #(
  parameter int DIVISOR = 54
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(DIVISOR - 1);
  always_ff @(posedge clk)
    if (!resetn) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled 8N1 receiver writing good bytes into the RX FIFO
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIVISOR   = 54,
  parameter int DATA_BITS = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            rx,
  uart_rx_core_if.master  bus
);
  localparam logic [3:0] MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] NLAST = 3'(DATA_BITS - 1);
  logic [1:0] sync;
  logic rx_s, tick;
  state_t state, state_d;
  logic [3:0] s_cnt, s_cnt_d;
  logic [2:0] n, n_d;
  logic [DATA_BITS-1:0] sh, sh_d, data_d;
  logic valid_d, ferr_d, ovr_d;
  assign rx_s = sync[1];
  assign bus.busy = state != IDLE;
  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (.clk(clk), .resetn(resetn), .tick(tick));
  always_comb begin
    state_d = state;
    s_cnt_d = s_cnt;
    n_d     = n;
    sh_d    = sh;
    data_d  = bus.rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_cnt_d = '0;
      end
      START: if (tick) begin
        s_cnt_d = s_cnt + 4'd1;
        if (s_cnt == MID) begin
          state_d = rx_s ? IDLE : DATA;
          s_cnt_d = '0;
          n_d     = '0;
        end
      end
      DATA: if (tick) begin
        s_cnt_d = s_cnt + 4'd1;
        if (s_cnt == LAST) begin
          sh_d    = {rx_s, sh[DATA_BITS-1:1]};
          n_d     = n + 3'd1;
          state_d = n == NLAST ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        s_cnt_d = s_cnt + 4'd1;
        if (s_cnt == LAST) begin
          state_d = rx_s ? IDLE : WAIT_HIGH;
          valid_d = rx_s && !bus.fifo_full;
          ovr_d   = rx_s && bus.fifo_full;
          ferr_d  = !rx_s;
          data_d  = valid_d ? sh : bus.rx_data;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync          <= 2'b11;
      state         <= IDLE;
      s_cnt         <= '0;
      n             <= '0;
      sh            <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      sync          <= {sync[0], rx};
      state         <= state_d;
      s_cnt         <= s_cnt_d;
      n             <= n_d;
      sh            <= sh_d;
      bus.rx_data   <= data_d;
      bus.rx_valid  <= valid_d;
      bus.frame_err <= ferr_d;
      bus.overrun   <= ovr_d;
    end
  end
endmodule
